// File: rtl/multi_channel_copy_engine.sv
// multi_channel_copy_engine: register-programmed memory-to-memory word copier with
// round-robin per-word arbitration between channels and one outstanding request.
// Revision: 1.0
`default_nettype none

module multi_channel_copy_engine #(
  parameter int ChannelCount = 2,
  parameter int AddrWidth    = 32,
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reg_valid,
  output logic                    reg_ready,
  input  logic                    reg_write,
  input  logic [AddrWidth-1:0]    reg_addr,
  input  logic [31:0]             reg_wdata,
  output logic                    reg_rvalid,
  output logic [31:0]             reg_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [AddrWidth-1:0]    mem_req_addr,
  output logic [DataWidth-1:0]    mem_req_wdata,
  input  logic                    mem_rsp_valid,
  input  logic [DataWidth-1:0]    mem_rsp_rdata,
  input  logic                    mem_rsp_error,
  output logic [ChannelCount-1:0] irq
);

  localparam int ChIdxW = (ChannelCount > 1) ? $clog2(ChannelCount) : 1;
  localparam logic [AddrWidth-1:0] STEP = AddrWidth'(DataWidth / 8);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARB     = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_WR_WAIT = 3'd5;

  logic [2:0]              state, state_nxt;
  logic [AddrWidth-1:0]    src [ChannelCount];
  logic [AddrWidth-1:0]    dst [ChannelCount];
  logic [LenWidth-1:0]     len [ChannelCount];
  logic [AddrWidth-1:0]    wsrc [ChannelCount];
  logic [AddrWidth-1:0]    wdst [ChannelCount];
  logic [LenWidth-1:0]     remaining [ChannelCount];
  logic [ChannelCount-1:0] busy, done, error;
  logic [ChIdxW-1:0]       cur, rr_ptr, grant;
  logic                    grant_found;
  logic [DataWidth-1:0]    data_q;
  logic                    rvalid_q;
  logic [31:0]             rdata_q, read_val;

  // Register decode: channel in bits [6:4], register in bits [3:2], word aligned.
  logic [2:0] sel_ch;
  logic [1:0] sel_reg;
  logic       mapped, reg_accept, wr_acc, rd_acc;

  assign sel_ch     = reg_addr[6:4];
  assign sel_reg    = reg_addr[3:2];
  assign mapped     = (reg_addr[AddrWidth-1:7] == '0) && (reg_addr[1:0] == 2'b00) &&
                      (int'(sel_ch) < ChannelCount);
  assign reg_accept = reg_valid && reg_ready;
  assign wr_acc     = reg_accept && reg_write && mapped;
  assign rd_acc     = reg_accept && !reg_write;

  logic                    rd_ok, wr_ok, abort, last_word, others_busy;
  logic [ChannelCount-1:0] cur_onehot;

  assign rd_ok       = (state == S_RD_WAIT) && mem_rsp_valid && !mem_rsp_error;
  assign wr_ok       = (state == S_WR_WAIT) && mem_rsp_valid && !mem_rsp_error;
  assign abort       = ((state == S_RD_WAIT) || (state == S_WR_WAIT)) && mem_rsp_valid && mem_rsp_error;
  assign last_word   = wr_ok && (remaining[cur] == LenWidth'(1));
  assign cur_onehot  = ChannelCount'(1) << cur;
  assign others_busy = |(busy & ~cur_onehot);

  // Round-robin search beginning at rr_ptr (the channel after the last grant).
  always_comb begin
    int idx;
    grant       = rr_ptr;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < ChannelCount; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= ChannelCount) idx = idx - ChannelCount;
      if (!grant_found && busy[ChIdxW'(idx)]) begin
        grant_found = 1'b1;
        grant       = ChIdxW'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (|busy) state_nxt = S_ARB;
      S_ARB:     state_nxt = grant_found ? S_RD_REQ : S_IDLE;
      S_RD_REQ:  if (mem_req_ready) state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_error) state_nxt = others_busy ? S_ARB : S_IDLE;
          else               state_nxt = S_WR_REQ;
        end
      end
      S_WR_REQ:  if (mem_req_ready) state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_error || last_word) state_nxt = others_busy ? S_ARB : S_IDLE;
          else                            state_nxt = S_ARB;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (!reset) begin
      if (state == S_RD_REQ) begin
        mem_req_valid = 1'b1;
        mem_req_addr  = wsrc[cur];
      end else if (state == S_WR_REQ) begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = wdst[cur];
        mem_req_wdata = data_q;
      end
    end
  end

  always_comb begin
    read_val = '0;
    for (int n = 0; n < ChannelCount; n++) begin
      if (int'(sel_ch) == n) begin
        case (sel_reg)
          2'd0:    read_val = 32'(src[n]);
          2'd1:    read_val = 32'(dst[n]);
          2'd2:    read_val = 32'(len[n]);
          default: read_val = {29'd0, error[n], done[n], busy[n]};
        endcase
      end
    end
    if (!mapped) read_val = '0;
  end

  // Channel state: software clears are applied before hardware sets so a same-cycle set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < ChannelCount; n++) begin
        src[n]       <= '0;
        dst[n]       <= '0;
        len[n]       <= '0;
        wsrc[n]      <= '0;
        wdst[n]      <= '0;
        remaining[n] <= '0;
      end
      busy     <= '0;
      done     <= '0;
      error    <= '0;
      cur      <= '0;
      rr_ptr   <= '0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if ((state == S_ARB) && grant_found) begin
        cur    <= grant;
        rr_ptr <= (int'(grant) == ChannelCount - 1) ? '0 : grant + 1'b1;
      end
      if (rd_ok) data_q <= mem_rsp_rdata;

      for (int n = 0; n < ChannelCount; n++) begin
        if (wr_acc && (int'(sel_ch) == n)) begin
          if (!busy[n]) begin
            case (sel_reg)
              2'd0:    src[n] <= AddrWidth'(reg_wdata);
              2'd1:    dst[n] <= AddrWidth'(reg_wdata);
              2'd2:    len[n] <= LenWidth'(reg_wdata);
              default: ;
            endcase
          end
          if (sel_reg == 2'd3) begin
            if (reg_wdata[1]) done[n]  <= 1'b0;
            if (reg_wdata[2]) error[n] <= 1'b0;
            if (reg_wdata[0] && !busy[n]) begin
              if (len[n] == '0) begin
                done[n] <= 1'b1;
              end else begin
                busy[n]      <= 1'b1;
                wsrc[n]      <= src[n];
                wdst[n]      <= dst[n];
                remaining[n] <= len[n];
              end
            end
          end
        end
        if (int'(cur) == n) begin
          if (abort) begin
            busy[n]  <= 1'b0;
            error[n] <= 1'b1;
            done[n]  <= 1'b1;
          end
          if (wr_ok) begin
            wsrc[n]      <= wsrc[n] + STEP;
            wdst[n]      <= wdst[n] + STEP;
            remaining[n] <= remaining[n] - 1'b1;
            if (last_word) begin
              busy[n] <= 1'b0;
              done[n] <= 1'b1;
            end
          end
        end
      end

      rvalid_q <= rd_acc;
      rdata_q  <= rd_acc ? read_val : '0;
    end
  end

  assign reg_ready  = !reset;
  assign reg_rvalid = rvalid_q && !reset;
  assign reg_rdata  = reset ? '0 : rdata_q;
  assign irq        = reset ? '0 : done;

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_copy_engine.sv
// tb_multi_channel_copy_engine: directed tests with a transaction-list model of expected memory traffic.
// Revision: 1.0
`default_nettype none

module tb_multi_channel_copy_engine;

  localparam int CH = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          reg_valid, reg_ready, reg_write, reg_rvalid;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wdata, reg_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid, mem_rsp_error;
  logic [DW-1:0] mem_rsp_rdata;
  logic [CH-1:0] irq;

  multi_channel_copy_engine #(
    .ChannelCount(CH), .AddrWidth(AW), .DataWidth(DW), .LenWidth(LW)
  ) dut (
    .clock(clock), .reset(reset),
    .reg_valid(reg_valid), .reg_ready(reg_ready), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_error(mem_rsp_error),
    .irq(irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] seen_rd[$];
  int          wr_count = 0;
  int          total = 0;
  int          bad = 0;
  int          err_read_idx = 0;
  int          reads_served = 0;

  function automatic logic [31:0] mdata(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Model: a copy is a list of read/write pairs, addresses stepping by 4 with 32-bit wrap.
  task automatic push_word(logic [31:0] s, logic [31:0] d);
    exp_q.push_back('{1'b0, s, 32'h0});
    exp_q.push_back('{1'b1, d, mdata(s)});
  endtask

  task automatic add_copy(logic [31:0] s, logic [31:0] d, int n);
    for (int i = 0; i < n; i++) push_word(s + 32'(4 * i), d + 32'(4 * i));
  endtask

  // Compare process: every presented request must match the head of the model list.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && mem_req_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req_valid", mem_req_valid, 1'b0);
        end else begin
          chk("req_write", mem_req_write, exp_q[0].wr);
          chk("req_addr", mem_req_addr, exp_q[0].addr);
          if (exp_q[0].wr) chk("req_wdata", mem_req_wdata, exp_q[0].data);
          if (mem_req_ready) void'(exp_q.pop_front());
        end
        if (mem_req_ready) begin
          if (mem_req_write) wr_count++;
          else               seen_rd.push_back(mem_req_addr);
        end
      end
    end
  end

  // Memory responder: one-cycle response to each accepted request.
  initial begin : responder
    bit          rd;
    bit          e;
    logic [31:0] a;
    mem_rsp_valid = 1'b0;
    mem_rsp_error = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clock);
      if (!reset && mem_req_valid && mem_req_ready) begin
        rd = !mem_req_write;
        a  = mem_req_addr;
        e  = 1'b0;
        if (rd) begin
          reads_served++;
          e = (reads_served == err_read_idx);
        end
        @(posedge clock);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rd ? mdata(a) : 32'hDEAD_BEEF;
        mem_rsp_error = e;
        @(posedge clock);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_error = 1'b0;
        mem_rsp_rdata = '0;
      end
    end
  end

  task automatic reg_wr(logic [31:0] a, logic [31:0] d);
    @(negedge clock);
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clock);
    reg_valid = 1'b0; reg_write = 1'b0;
  endtask

  task automatic rd_chk(string name, logic [31:0] a, logic [31:0] expv);
    @(negedge clock);
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a;
    @(negedge clock);
    reg_valid = 1'b0;
    chk({name, "_rvalid"}, reg_rvalid, 1'b1);
    chk(name, reg_rdata, expv);
  endtask

  task automatic wait_empty(string name, int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_irq(int idx, string name, int budget);
    int n = 0;
    while (!irq[idx] && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(name, irq[idx], 1'b1);
  endtask

  task automatic set_ready(bit v);
    @(posedge clock);
    #1 mem_req_ready = v;
  endtask

  initial begin
    reset = 1'b1; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
    mem_req_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_reg_ready", reg_ready, 1'b0);
    chk("rst_irq", irq, 2'b00);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_rvalid", reg_rvalid, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reg_ready", reg_ready, 1'b1);
    rd_chk("rst_status0", 32'h0C, 32'h0);
    reg_wr(32'h40, 32'h1234);
    rd_chk("unmapped", 32'h40, 32'h0);

    // Single-channel copy of four words
    seen_rd.delete(); wr_count = 0;
    add_copy(32'h1000, 32'h2000, 4);
    reg_wr(32'h00, 32'h1000);
    reg_wr(32'h04, 32'h2000);
    reg_wr(32'h08, 32'd4);
    rd_chk("t1_src_rb", 32'h00, 32'h1000);
    reg_wr(32'h0C, 32'h1);
    rd_chk("t1_busy", 32'h0C, 32'h1);
    reg_wr(32'h00, 32'hDEAD_0000);
    wait_empty("t1_drain", 300);
    wait_irq(0, "t1_irq_rise", 50);
    chk("t1_irq", irq, 2'b01);
    rd_chk("t1_status", 32'h0C, 32'h2);
    rd_chk("t1_src_locked", 32'h00, 32'h1000);
    chk("t1_writes", wr_count, 4);
    chk("t1_rd3_addr", seen_rd[3], 32'h100C);
    reg_wr(32'h0C, 32'h2);
    chk("t1_irq_clr", irq, 2'b00);

    // Two channels interleave word by word
    seen_rd.delete(); wr_count = 0;
    for (int i = 0; i < 3; i++) begin
      push_word(32'h3000 + 32'(4 * i), 32'h4000 + 32'(4 * i));
      push_word(32'h5000 + 32'(4 * i), 32'h6000 + 32'(4 * i));
    end
    reg_wr(32'h00, 32'h3000); reg_wr(32'h04, 32'h4000); reg_wr(32'h08, 32'd3);
    reg_wr(32'h10, 32'h5000); reg_wr(32'h14, 32'h6000); reg_wr(32'h18, 32'd3);
    reg_wr(32'h0C, 32'h1);
    reg_wr(32'h1C, 32'h1);
    wait_irq(0, "t2_irq0", 300);
    chk("t2_ch0_first", irq[1], 1'b0);
    wait_empty("t2_drain", 100);
    wait_irq(1, "t2_irq1", 50);
    chk("t2_irq_both", irq, 2'b11);
    chk("t2_rd1_addr", seen_rd[1], 32'h5000);
    reg_wr(32'h0C, 32'h2);
    reg_wr(32'h1C, 32'h2);
    chk("t2_irq_clr", irq, 2'b00);

    // Zero-length start
    reg_wr(32'h08, 32'd0);
    chk("t3_irq_pre", irq, 2'b00);
    reg_wr(32'h0C, 32'h1);
    chk("t3_irq_rise", irq[0], 1'b1);
    repeat (5) begin
      @(negedge clock);
      chk("t3_no_req", mem_req_valid, 1'b0);
    end
    rd_chk("t3_status", 32'h0C, 32'h2);
    reg_wr(32'h0C, 32'h2);
    chk("t3_irq_fall", irq[0], 1'b0);

    // Error on the second read aborts after one write
    seen_rd.delete(); wr_count = 0; reads_served = 0; err_read_idx = 2;
    push_word(32'h7000, 32'h8000);
    exp_q.push_back('{1'b0, 32'h7004, 32'h0});
    reg_wr(32'h00, 32'h7000); reg_wr(32'h04, 32'h8000); reg_wr(32'h08, 32'd4);
    reg_wr(32'h0C, 32'h1);
    wait_empty("t4_drain", 200);
    repeat (20) @(negedge clock);
    chk("t4_writes", wr_count, 1);
    rd_chk("t4_status", 32'h0C, 32'h6);
    chk("t4_irq", irq, 2'b01);
    reg_wr(32'h0C, 32'h6);
    rd_chk("t4_status_clr", 32'h0C, 32'h0);
    err_read_idx = 0;

    // Source address wraps past the top of the address space
    seen_rd.delete(); wr_count = 0;
    add_copy(32'hFFFF_FFFC, 32'h9000, 2);
    reg_wr(32'h00, 32'hFFFF_FFFC); reg_wr(32'h04, 32'h9000); reg_wr(32'h08, 32'd2);
    reg_wr(32'h0C, 32'h1);
    wait_empty("t5_drain", 200);
    wait_irq(0, "t5_irq", 50);
    chk("t5_rd_count", seen_rd.size(), 2);
    chk("t5_rd1_addr", seen_rd[1], 32'h0000_0000);
    rd_chk("t5_status", 32'h0C, 32'h2);
    reg_wr(32'h0C, 32'h2);

    // Back-pressure, then reset in the middle of the transfer
    set_ready(1'b0);
    add_copy(32'hA000, 32'hB000, 4);
    reg_wr(32'h10, 32'hA000); reg_wr(32'h14, 32'hB000); reg_wr(32'h18, 32'd4);
    reg_wr(32'h1C, 32'h1);
    begin
      int n = 0;
      while (!mem_req_valid && n < 50) begin
        @(negedge clock);
        n++;
      end
    end
    chk("t6_req_seen", mem_req_valid, 1'b1);
    repeat (5) begin
      @(negedge clock);
      chk("t6_stall_valid", mem_req_valid, 1'b1);
      chk("t6_stall_addr", mem_req_addr, 32'hA000);
      chk("t6_stall_write", mem_req_write, 1'b0);
    end
    set_ready(1'b1);
    begin
      int n = 0;
      while (exp_q.size() > 5 && n < 100) begin
        @(negedge clock);
        n++;
      end
    end
    chk("t6_progress", exp_q.size(), 5);
    @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) begin
      @(negedge clock);
      chk("t6_no_req_after_rst", mem_req_valid, 1'b0);
    end
    chk("t6_irq", irq, 2'b00);
    rd_chk("t6_status1", 32'h1C, 32'h0);
    rd_chk("t6_status0", 32'h0C, 32'h0);
    rd_chk("t6_src1", 32'h10, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
